// File: rtl/wembley_nibble_feeder_if.sv
// rtl/wembley_nibble_feeder_if.sv - word-triple handshake and nibble output bundle for wembley_nibble_feeder
interface wembley_nibble_feeder_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] A_word;
    logic [WORD_W-1:0] B_word;
    logic [WORD_W-1:0] C_word;
    logic              hold;
    logic [3:0]        Ain;
    logic [3:0]        Bin;
    logic [3:0]        Cin;
    logic              nib_valid;
    logic              nib_first;
    logic              nib_last;
    logic              busy;
    logic [CNT_W-1:0]  word_cnt;

    modport master (
        output in_valid, A_word, B_word, C_word, hold,
        input  in_ready, Ain, Bin, Cin, nib_valid, nib_first, nib_last, busy, word_cnt
    );

    modport slave (
        input  in_valid, A_word, B_word, C_word, hold,
        output in_ready, Ain, Bin, Cin, nib_valid, nib_first, nib_last, busy, word_cnt
    );
endinterface

// File: rtl/wembley_nibble_feeder.sv
// rtl/wembley_nibble_feeder.sv - serialises A/B/C word triples into nibble triples with one pending slot
// Optional build macro WEMBLEY_FEEDER_MSB_FIRST_EN selects most-significant-nibble-first order.
module wembley_nibble_feeder #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 8
) (
    input logic                  clk,
    input logic                  reset,
    wembley_nibble_feeder_if.slave bus
);
    localparam int NUM   = WORD_W / 4;
    localparam int IDX_W = $clog2(NUM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_sa, r_sb, r_sc;
    logic [WORD_W-1:0] r_pa, r_pb, r_pc;
    logic              r_pend_v;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_word_cnt;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_at_last;
    logic       w_shift;
    logic [3:0] w_head_a, w_head_b, w_head_c;

    // The shifter always presents the current nibble at its head end, so advancing is a 4-bit shift.
    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
`ifdef WEMBLEY_FEEDER_MSB_FIRST_EN
        return w << 4;
`else
        return w >> 4;
`endif
    endfunction

`ifdef WEMBLEY_FEEDER_MSB_FIRST_EN
    assign w_head_a = r_sa[WORD_W-1 -: 4];
    assign w_head_b = r_sb[WORD_W-1 -: 4];
    assign w_head_c = r_sc[WORD_W-1 -: 4];
`else
    assign w_head_a = r_sa[3:0];
    assign w_head_b = r_sb[3:0];
    assign w_head_c = r_sc[3:0];
`endif

    assign w_in_ready = !reset && !bus.hold && !r_pend_v;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_at_last  = (r_idx == IDX_LAST);
    assign w_shift    = (r_state == S_SHIFT);

    assign bus.in_ready  = w_in_ready;
    assign bus.nib_valid = w_shift;
    assign bus.nib_first = w_shift && (r_idx == '0);
    assign bus.nib_last  = w_shift && w_at_last;
    assign bus.Ain       = w_shift ? w_head_a : 4'h0;
    assign bus.Bin       = w_shift ? w_head_b : 4'h0;
    assign bus.Cin       = w_shift ? w_head_c : 4'h0;
    assign bus.busy      = w_shift || r_pend_v;
    assign bus.word_cnt  = r_word_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sa       <= '0;
            r_sb       <= '0;
            r_sc       <= '0;
            r_pa       <= '0;
            r_pb       <= '0;
            r_pc       <= '0;
            r_pend_v   <= 1'b0;
            r_idx      <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sa    <= bus.A_word;
                        r_sb    <= bus.B_word;
                        r_sc    <= bus.C_word;
                        r_idx   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!bus.hold) begin
                        if (!w_at_last) begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_sa  <= advance(r_sa);
                            r_sb  <= advance(r_sb);
                            r_sc  <= advance(r_sc);
                            if (w_accept) begin
                                r_pa     <= bus.A_word;
                                r_pb     <= bus.B_word;
                                r_pc     <= bus.C_word;
                                r_pend_v <= 1'b1;
                            end
                        end else if (r_pend_v) begin
                            r_sa     <= r_pa;
                            r_sb     <= r_pb;
                            r_sc     <= r_pc;
                            r_pend_v <= 1'b0;
                            r_idx    <= '0;
                        end else if (w_accept) begin
                            // Last nibble going out with nothing pending: new word bypasses the buffer.
                            r_sa  <= bus.A_word;
                            r_sb  <= bus.B_word;
                            r_sc  <= bus.C_word;
                            r_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wembley_nibble_feeder.sv
// tb/tb_wembley_nibble_feeder.sv - self-checking bench for wembley_nibble_feeder
module tb_wembley_nibble_feeder;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 8;
    localparam int NUM    = WORD_W / 4;

    localparam logic [WORD_W-1:0] A0 = 32'h87654321;
    localparam logic [WORD_W-1:0] B0 = 32'hFEDCBA98;
    localparam logic [WORD_W-1:0] C0 = 32'h0F0F0F0F;

`ifdef WEMBLEY_FEEDER_MSB_FIRST_EN
    localparam logic [3:0] EA [0:7] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    localparam logic [3:0] EB [0:7] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    localparam logic [3:0] EC [0:7] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
`else
    localparam logic [3:0] EA [0:7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    localparam logic [3:0] EB [0:7] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    localparam logic [3:0] EC [0:7] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
`endif
    localparam int HOLD_IDX [0:10] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};
    localparam int CNT2_SEQ [0:4]  = '{1, 2, 3, 0, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wembley_nibble_feeder_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();
    wembley_nibble_feeder_if #(.WORD_W(WORD_W), .CNT_W(2))     bus2 ();

    wembley_nibble_feeder #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    wembley_nibble_feeder #(.WORD_W(WORD_W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    assign bus2.in_valid = bus.in_valid;
    assign bus2.hold     = bus.hold;
    assign bus2.A_word   = bus.A_word;
    assign bus2.B_word   = bus.B_word;
    assign bus2.C_word   = bus.C_word;

    int tests = 0;
    int fails = 0;

    // Reference: queue of accepted-but-unfinished words plus the position within the head word.
    logic [WORD_W-1:0] qa[$], qb[$], qc[$];
    int          pos = 0;
    int unsigned mcnt = 0;
    bit          prev_acc = 0;
    int          cnt2_seq[$];

    logic       s_valid, s_first, s_last, s_ready, s_busy;
    logic [3:0] s_a, s_b, s_c;
    logic [CNT_W-1:0] s_cnt;
    logic [1:0] s_cnt2;

    typedef struct {
        logic       v;
        logic       ev, ef, el;
        logic [3:0] ea, eb, ec;
    } vec_t;
    vec_t tbl [0:9];

    function automatic logic [3:0] nib(input logic [WORD_W-1:0] w, input int p);
`ifdef WEMBLEY_FEEDER_MSB_FIRST_EN
        return 4'(w >> (4 * (NUM - 1 - p)));
`else
        return 4'(w >> (4 * p));
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic h, input logic r,
                        input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                        input logic [WORD_W-1:0] c);
        logic exp_ready;
        logic acc;
        reset = r;
        bus.in_valid = v;
        bus.hold = h;
        bus.A_word = a;
        bus.B_word = b;
        bus.C_word = c;
        @(negedge clk);
        s_valid = bus.nib_valid;
        s_first = bus.nib_first;
        s_last  = bus.nib_last;
        s_ready = bus.in_ready;
        s_busy  = bus.busy;
        s_a = bus.Ain;
        s_b = bus.Bin;
        s_c = bus.Cin;
        s_cnt  = bus.word_cnt;
        s_cnt2 = bus2.word_cnt;
        exp_ready = !r && !h && (qa.size() < 2);
        if (qa.size() > 0)
            chk("model_nibbles", {s_valid, s_first, s_last, s_a, s_b, s_c},
                {1'b1, pos == 0, pos == NUM - 1, nib(qa[0], pos), nib(qb[0], pos), nib(qc[0], pos)});
        else
            chk("model_nibbles", {s_valid, s_first, s_last, s_a, s_b, s_c}, 64'd0);
        chk("model_in_ready", s_ready, exp_ready);
        chk("model_busy", s_busy, qa.size() > 0);
        chk("model_word_cnt", s_cnt, mcnt % (1 << CNT_W));
        chk("model_word_cnt_w2", s_cnt2, mcnt % 4);
        if (prev_acc && cnt2_seq.size() < 5) cnt2_seq.push_back(int'(s_cnt2));
        acc = v && exp_ready;
        prev_acc = acc;
        @(posedge clk);
        if (r) begin
            qa.delete(); qb.delete(); qc.delete();
            pos = 0;
            mcnt = 0;
        end else begin
            if (qa.size() > 0 && !h) begin
                pos++;
                if (pos == NUM) begin
                    void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
                    pos = 0;
                end
            end
            if (acc) begin
                qa.push_back(a); qb.push_back(b); qc.push_back(c);
                mcnt++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int accepted, first, last, nval, nlast;
        bit saw_stall;
        int hseq[$];

        tbl[0] = '{v: 1'b1, ev: 1'b0, ef: 1'b0, el: 1'b0, ea: 4'h0, eb: 4'h0, ec: 4'h0};
        for (int i = 0; i < 8; i++)
            tbl[i+1] = '{v: 1'b0, ev: 1'b1, ef: (i == 0), el: (i == 7), ea: EA[i], eb: EB[i], ec: EC[i]};
        tbl[9] = '{v: 1'b0, ev: 1'b0, ef: 1'b0, el: 1'b0, ea: 4'h0, eb: 4'h0, ec: 4'h0};

        // Reset then idle
        step(1'b1, 1'b0, 1'b1, A0, B0, C0);
        chk("ready_in_reset", s_ready, 1'b0);
        step(1'b0, 1'b0, 1'b1, '0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("reset_outputs", {s_valid, s_first, s_last, s_a, s_b, s_c, s_busy, s_cnt}, 64'd0);
        chk("reset_ready", s_ready, 1'b1);

        // Single triple, table-driven
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, 1'b0, 1'b0, A0, B0, C0);
            chk($sformatf("tbl_nib_%0d", i), {s_valid, s_first, s_last, s_a, s_b, s_c},
                {tbl[i].ev, tbl[i].ef, tbl[i].el, tbl[i].ea, tbl[i].eb, tbl[i].ec});
        end
        chk("single_word_cnt", s_cnt, 1);

        // Three triples back-to-back
        accepted = 0; first = -1; last = -1; nval = 0; saw_stall = 0;
        for (int k = 0; k < 40; k++) begin
            logic v;
            v = (accepted < 3);
            step(v, 1'b0, 1'b0, $urandom, $urandom, $urandom);
            if (v && s_ready) accepted++;
            if (v && !s_ready && s_busy) saw_stall = 1;
            if (s_valid) begin
                nval++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("b2b_valid_cycles", nval, 24);
        chk("b2b_contiguous", last - first + 1, 24);
        chk("b2b_ready_stall", saw_stall, 1'b1);
        chk("b2b_word_cnt", s_cnt, 4);

        // Hold for 3 cycles at idx 4
        step(1'b1, 1'b0, 1'b0, A0, B0, C0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, (k >= 4 && k < 7), 1'b0, '0, '0, '0);
            if (s_valid) hseq.push_back(int'(s_a));
        end
        chk("hold_word_len", hseq.size(), 11);
        for (int i = 0; i < 11 && i < hseq.size(); i++)
            chk($sformatf("hold_ain_%0d", i), hseq[i], EA[HOLD_IDX[i]]);

        // Reset at idx 5 with a pending word
        step(1'b1, 1'b0, 1'b0, A0, B0, C0);
        step(1'b1, 1'b0, 1'b0, ~A0, ~B0, ~C0);
        chk("pend_accept", s_ready, 1'b1);
        nlast = 0;
        for (int k = 1; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0, '0);
            if (s_last) nlast++;
        end
        step(1'b0, 1'b0, 1'b1, '0, '0, '0);
        chk("pre_reset_busy", s_busy, 1'b1);
        chk("pre_reset_ain", s_a, EA[5]);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("post_reset_outputs", {s_valid, s_first, s_last, s_a, s_b, s_c, s_busy, s_cnt}, 64'd0);
        chk("post_reset_ready", s_ready, 1'b1);
        nval = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0, '0);
            if (s_last) nlast++;
            if (s_valid) nval++;
        end
        chk("reset_no_last", nlast, 0);
        chk("reset_pending_lost", nval, 0);

        // Narrow counter wrap over the first five accepts
        chk("cnt_w2_len", cnt2_seq.size(), 5);
        for (int i = 0; i < 5 && i < cnt2_seq.size(); i++)
            chk($sformatf("cnt_w2_seq_%0d", i), cnt2_seq[i], CNT2_SEQ[i]);

        // Random traffic against the queue model
        for (int k = 0; k < 3000; k++)
            step(($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 250) == 0,
                 $urandom, $urandom, $urandom);
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
